// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared state encodings, default display words and rotate helper
// for the 8-digit display sequencer.
package disp_pkg;

  typedef enum logic [1:0] {
    S_EDIT  = 2'd0,
    S_SHIFT = 2'd1,
    S_WAVE  = 2'd2,
    S_LOAD  = 2'd3
  } state_t;

  localparam logic [31:0] DEF_INIT_VAL   = 32'h1234_5678;
  localparam logic [31:0] DEF_WAVE_A     = 32'hDEFE_DEFE;
  localparam logic [31:0] DEF_WAVE_B     = 32'hEFDE_EFDE;
  localparam int          DEF_HOLD_TICKS = 4;

  // Left moves the top nibble into digit 0; right moves digit 0 to the top.
  function automatic logic [31:0] rotate_word(input logic [31:0] w, input logic left);
    return left ? {w[27:0], w[31:28]} : {w[3:0], w[31:4]};
  endfunction

endpackage

// File: rtl/btn_edge_det.sv
// rtl/btn_edge_det.sv - 8-bit rising-edge detector against the registered previous level.
module btn_edge_det (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_lvl,
  output logic [7:0] o_rise
);

  logic [7:0] r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '0;
    end else begin
      r_prev <= i_lvl;
    end
  end

  assign o_rise = i_lvl & ~r_prev;

endmodule

// File: rtl/disp_seq_ctrl.sv
// rtl/disp_seq_ctrl.sv - display word sequencer: tick-paced load/rotate/wave modes plus
// per-digit button edits; optional hold-to-repeat under DISP_AUTOREPEAT_EN.
module disp_seq_ctrl
  import disp_pkg::*;
#(
  parameter logic [31:0] INIT_VAL = DEF_INIT_VAL,
  parameter logic [31:0] WAVE_A   = DEF_WAVE_A,
  parameter logic [31:0] WAVE_B   = DEF_WAVE_B
`ifdef DISP_AUTOREPEAT_EN
  ,
  parameter int          HOLD_TICKS = DEF_HOLD_TICKS
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        reload,
  input  logic        shift_en,
  input  logic        wave_en,
  input  logic        dir,
  input  logic [7:0]  btn_lvl,
  output logic [31:0] disp_num,
  output logic [1:0]  state,
  output logic [7:0]  step_cnt
);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_word;
  logic [31:0] w_word_nxt;
  logic [7:0]  r_step;
  logic [7:0]  w_step_nxt;
  logic        r_phase;
  logic        w_phase_nxt;
  logic [7:0]  w_rise;
  logic [7:0]  w_inc;

  btn_edge_det u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_lvl  (btn_lvl),
    .o_rise (w_rise)
  );

`ifdef DISP_AUTOREPEAT_EN
  localparam int HW = $clog2(HOLD_TICKS + 1);
  logic [HW-1:0] r_hold [8];
  logic [7:0]    w_rpt;

  // Counters only run while the word stays editable; anything else restarts the hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_hold[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (!btn_lvl[i] || (w_next_state != S_EDIT)) begin
          r_hold[i] <= '0;
        end else if (tick && (r_hold[i] != HW'(HOLD_TICKS))) begin
          r_hold[i] <= r_hold[i] + HW'(1);
        end
      end
    end
  end

  always_comb begin
    w_rpt = '0;
    for (int i = 0; i < 8; i++) begin
      w_rpt[i] = tick && btn_lvl[i] && (r_hold[i] == HW'(HOLD_TICKS));
    end
  end

  assign w_inc = w_rise | w_rpt;
`else
  assign w_inc = w_rise;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EDIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (tick) begin
      if (reload)        w_next_state = S_LOAD;
      else if (shift_en) w_next_state = S_SHIFT;
      else if (wave_en)  w_next_state = S_WAVE;
      else               w_next_state = S_EDIT;
    end
  end

  always_comb begin
    w_word_nxt  = r_word;
    w_step_nxt  = r_step;
    w_phase_nxt = r_phase;
    if (tick) begin
      case (w_next_state)
        S_LOAD: begin
          w_word_nxt = INIT_VAL;
          w_step_nxt = '0;
        end
        S_SHIFT: begin
          w_word_nxt = rotate_word(r_word, dir);
          w_step_nxt = r_step + 8'd1;
        end
        S_WAVE: begin
          // Entering the wave always shows frame A first, whatever the stale phase.
          if (r_state != S_WAVE) begin
            w_word_nxt  = WAVE_A;
            w_phase_nxt = 1'b1;
          end else begin
            w_word_nxt  = r_phase ? WAVE_B : WAVE_A;
            w_phase_nxt = ~r_phase;
          end
          w_step_nxt = r_step + 8'd1;
        end
        default: begin
          w_step_nxt = '0;
        end
      endcase
    end
    if (w_next_state == S_EDIT) begin
      for (int i = 0; i < 8; i++) begin
        if (w_inc[i]) w_word_nxt[4*i +: 4] = w_word_nxt[4*i +: 4] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word  <= INIT_VAL;
      r_step  <= '0;
      r_phase <= 1'b0;
    end else begin
      r_word  <= w_word_nxt;
      r_step  <= w_step_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  assign disp_num = r_word;
  assign state    = r_state;
  assign step_cnt = r_step;

endmodule

// File: tb/tb_disp_seq_ctrl.sv
// tb/tb_disp_seq_ctrl.sv - self-checking bench: behavioural display model, per-cycle compare,
// directed literal checks and randomized control/button stimulus.
module tb_disp_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        reload = 1'b0;
  logic        shift_en = 1'b0;
  logic        wave_en = 1'b0;
  logic        dir = 1'b0;
  logic [7:0]  btn_lvl = 8'h00;
  logic [31:0] disp_num;
  logic [1:0]  state;
  logic [7:0]  step_cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  // Model state: mode as 0 edit, 1 shift, 2 wave, 3 load.
  logic [31:0] m_word;
  int          m_mode;
  int          m_step;
  bit          m_phase;
  logic [7:0]  m_prev;

  logic [31:0] n_word;
  int          n_mode;
  int          n_step;
  bit          n_phase;

  disp_seq_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .reload   (reload),
    .shift_en (shift_en),
    .wave_en  (wave_en),
    .dir      (dir),
    .btn_lvl  (btn_lvl),
    .disp_num (disp_num),
    .state    (state),
    .step_cnt (step_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_word  = 32'h1234_5678;
    m_mode  = 0;
    m_step  = 0;
    m_phase = 1'b0;
    m_prev  = 8'h00;
  endtask

  task automatic model_predict();
    int nib;
    n_word  = m_word;
    n_mode  = m_mode;
    n_step  = m_step;
    n_phase = m_phase;
    if (tick) begin
      n_mode = reload ? 3 : shift_en ? 1 : wave_en ? 2 : 0;
      if (n_mode == 3) begin
        n_word = 32'h1234_5678;
        n_step = 0;
      end else if (n_mode == 1) begin
        if (dir) n_word = (m_word << 4) | (m_word >> 28);
        else     n_word = (m_word >> 4) | (m_word << 28);
        n_step = (m_step + 1) % 256;
      end else if (n_mode == 2) begin
        if (m_mode != 2) begin
          n_word  = 32'hDEFE_DEFE;
          n_phase = 1'b1;
        end else begin
          n_word  = m_phase ? 32'hEFDE_EFDE : 32'hDEFE_DEFE;
          n_phase = !m_phase;
        end
        n_step = (m_step + 1) % 256;
      end else begin
        n_step = 0;
      end
    end
    if (n_mode == 0) begin
      for (int i = 0; i < 8; i++) begin
        if (btn_lvl[i] && !m_prev[i]) begin
          nib    = int'((n_word >> (4 * i)) & 32'hF);
          n_word = n_word - (32'(nib) << (4 * i)) + (32'((nib + 1) % 16) << (4 * i));
        end
      end
    end
  endtask

  task automatic cyc(input logic t, input logic r, input logic s, input logic w,
                     input logic d, input logic [7:0] b);
    tick = t; reload = r; shift_en = s; wave_en = w; dir = d; btn_lvl = b;
    model_predict();
    @(posedge clk);
    #1;
    m_word  = n_word;
    m_mode  = n_mode;
    m_step  = n_step;
    m_phase = n_phase;
    m_prev  = btn_lvl;
  endtask

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("model_disp_num", disp_num, m_word);
      check("model_state", 32'(state), 32'(m_mode));
      check("model_step_cnt", 32'(step_cnt), 32'(m_step));
    end
  end

  initial begin
    logic [7:0] b;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_disp_num", disp_num, 32'h1234_5678);
    check("reset_state", 32'(state), 32'd0);
    check("reset_step_cnt", 32'(step_cnt), 32'd0);
    cmp_en = 1'b1;

    repeat (3) cyc(1, 0, 0, 0, 0, 8'h00);
    check("idle_ticks_word", disp_num, 32'h1234_5678);
    check("idle_ticks_state", 32'(state), 32'd0);

    cyc(1, 0, 1, 0, 1, 8'h00);
    check("rotl_1", disp_num, 32'h2345_6781);
    cyc(0, 0, 1, 0, 1, 8'h00);
    check("no_tick_hold", disp_num, 32'h2345_6781);
    cyc(1, 0, 1, 0, 1, 8'h00);
    check("rotl_2", disp_num, 32'h3456_7812);
    check("rotl_step", 32'(step_cnt), 32'd2);
    cyc(1, 0, 1, 0, 0, 8'h00);
    check("rotr_1", disp_num, 32'h2345_6781);

    cyc(1, 0, 0, 1, 0, 8'h00);
    check("wave_1", disp_num, 32'hDEFE_DEFE);
    cyc(1, 0, 0, 1, 0, 8'h00);
    check("wave_2", disp_num, 32'hEFDE_EFDE);
    cyc(1, 0, 0, 1, 0, 8'h00);
    check("wave_3", disp_num, 32'hDEFE_DEFE);
    check("wave_state", 32'(state), 32'd2);
    check("shift_wave_step", 32'(step_cnt), 32'd6);
    cyc(1, 0, 0, 0, 0, 8'h00);
    check("edit_step_clr", 32'(step_cnt), 32'd0);
    cyc(1, 0, 0, 1, 0, 8'h00);
    check("wave_reentry", disp_num, 32'hDEFE_DEFE);
    cyc(1, 0, 0, 0, 0, 8'h00);

    cyc(0, 0, 0, 0, 0, 8'h01);
    cyc(0, 0, 0, 0, 0, 8'h00);
    check("nib0_to_f", disp_num, 32'hDEFE_DEFF);
    cyc(0, 0, 0, 0, 0, 8'h01);
    check("nib0_wrap", disp_num, 32'hDEFE_DEF0);
    cyc(0, 0, 0, 0, 0, 8'h01);
    check("held_no_repeat", disp_num, 32'hDEFE_DEF0);
    cyc(0, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 8'hFF);
    check("all_nibbles", disp_num, 32'hEF0F_EF01);
    cyc(0, 0, 0, 0, 0, 8'h00);

    cyc(1, 1, 1, 0, 0, 8'h01);
    check("load_state", 32'(state), 32'd3);
    check("load_word", disp_num, 32'h1234_5678);
    cyc(1, 0, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 0, 8'h02);
    check("edit_on_tick", disp_num, 32'h1234_5688);
    cyc(1, 0, 1, 0, 1, 8'h00);
    cyc(0, 0, 1, 0, 1, 8'h04);
    check("edit_in_shift_dropped", disp_num, 32'h2345_6881);
    cyc(1, 0, 0, 0, 0, 8'h00);

    for (int i = 0; i < 256; i++) cyc(1, 0, 1, 0, i[0], 8'h00);
    check("step_wrap", 32'(step_cnt), 32'd0);
    cyc(1, 0, 1, 0, 1, 8'h00);
    check("step_after_wrap", 32'(step_cnt), 32'd1);

    b = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      b = b ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      cyc(($urandom % 3) == 0, ($urandom % 16) == 0, ($urandom % 3) == 0,
          ($urandom % 2) == 0, 1'($urandom), b);
      if (n == 1500) begin
        cyc(1, 0, 1, 0, 1, b);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_word", disp_num, 32'h1234_5678);
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_step", 32'(step_cnt), 32'd0);
        model_reset();
        b = 8'h00;
        btn_lvl = b;
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
